// File: rtl/queue_instruction_decoder.sv
// Purpose: pops bytes from the prefetch queue and assembles one 8088 instruction record.
// Latency: one fetch cycle plus GAP_CYCLES per byte; record valid the cycle after the last gap.
// Backpressure: holds the record (no fetches) until instReady; stalls while prefetchEmpty.
`timescale 1ns/1ps
module queue_instruction_decoder #(
  parameter int GAP_CYCLES = 1,
  parameter int MAX_LEN    = 15
) (
  input  logic        CLKx4,
  input  logic        RESET,
  input  logic [7:0]  prefetchTop,
  input  logic        prefetchEmpty,
  input  logic        flush,
  output logic        advanceTop,
  output logic        instValid,
  input  logic        instReady,
  output logic [7:0]  instOpcode,
  output logic        instHasModrm,
  output logic [7:0]  instModrm,
  output logic [15:0] instDisp,
  output logic [31:0] instImm,
  output logic [2:0]  instSeg,
  output logic [1:0]  instRep,
  output logic        instLock,
  output logic [3:0]  instLength
);

  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  typedef enum logic [3:0] {
    S_PREFIX_OPC, S_MODRM, S_DISP0, S_DISP1,
    S_IMM0, S_IMM1, S_IMM2, S_IMM3, S_GAP, S_DONE
  } state_t;

  state_t        state, state_nxt;
  state_t        ret_state, ret_nxt;
  logic [GW-1:0] gap_cnt;
  logic          gap_last;
  logic          take;
  logic [2:0]    il_cur;
  logic [1:0]    dl_cur;

  function automatic logic is_prefix(input logic [7:0] b);
    return (b == 8'h26) || (b == 8'h2E) || (b == 8'h36) || (b == 8'h3E) ||
           (b == 8'hF0) || (b == 8'hF2) || (b == 8'hF3);
  endfunction

  function automatic logic has_modrm(input logic [7:0] op);
    logic r;
    r = 1'b0;
    if (op[7:6] == 2'b00 && !op[2]) r = 1'b1;
    if (op[7:4] == 4'h8)            r = 1'b1;   // 80-8F
    if (op[7:2] == 6'b110001)       r = 1'b1;   // C4-C7
    if (op[7:2] == 6'b110100)       r = 1'b1;   // D0-D3
    if (op[7:3] == 5'b11011)        r = 1'b1;   // D8-DF (ESC)
    if (op == 8'hF6 || op == 8'hF7 || op == 8'hFE || op == 8'hFF) r = 1'b1;
    return r;
  endfunction

  // rg is the ModRM reg field; only group-3 (F6/F7) uses it, and those always carry ModRM
  function automatic logic [2:0] imm_len(input logic [7:0] op, input logic [2:0] rg);
    logic [2:0] n;
    n = 3'd0;
    if (op[7:6] == 2'b00 && op[2:0] == 3'b100) n = 3'd1;
    if (op[7:6] == 2'b00 && op[2:0] == 3'b101) n = 3'd2;
    if (op[7:4] == 4'h7) n = 3'd1;                                   // Jcc rel8
    if (op[7:3] == 5'b10110 || op[7:3] == 5'b11100) n = 3'd1;        // B0-B7, E0-E7
    if (op[7:3] == 5'b10111 || op[7:2] == 6'b101000) n = 3'd2;       // B8-BF, A0-A3
    case (op)
      8'h80, 8'h82, 8'h83, 8'hA8, 8'hC6, 8'hCD, 8'hD4, 8'hD5, 8'hEB: n = 3'd1;
      8'h81, 8'hA9, 8'hC2, 8'hCA, 8'hC7, 8'hE8, 8'hE9:               n = 3'd2;
      8'h9A, 8'hEA:                                                   n = 3'd4;
      8'hF6: n = (rg == 3'b000) ? 3'd1 : 3'd0;
      8'hF7: n = (rg == 3'b000) ? 3'd2 : 3'd0;
      default: ;
    endcase
    return n;
  endfunction

  function automatic logic [1:0] disp_len(input logic [7:0] m);
    logic [1:0] n;
    n = 2'd0;
    if (m[7:6] == 2'b01) n = 2'd1;
    if (m[7:6] == 2'b10) n = 2'd2;
    if (m[7:6] == 2'b00 && m[2:0] == 3'b110) n = 2'd2;
    return n;
  endfunction

  function automatic state_t imm_or_done(input logic [2:0] n);
    return (n != 3'd0) ? S_IMM0 : S_DONE;
  endfunction

  assign il_cur    = imm_len(instOpcode, instModrm[5:3]);
  assign dl_cur    = disp_len(instModrm);
  assign gap_last  = (gap_cnt == GW'(GAP_CYCLES - 1));
  assign instValid = (state == S_DONE);

  // state register and the fetch state to resume after the gap
  always_ff @(posedge CLKx4) begin
    if (RESET) begin
      state     <= S_PREFIX_OPC;
      ret_state <= S_PREFIX_OPC;
    end else begin
      state     <= state_nxt;
      ret_state <= ret_nxt;
    end
  end

  // next state, pop strobe, and where the byte being consumed leads
  always_comb begin
    state_nxt  = state;
    ret_nxt    = ret_state;
    advanceTop = 1'b0;
    take       = 1'b0;
    case (state)
      S_GAP:  if (gap_last)  state_nxt = ret_state;
      S_DONE: if (instReady) state_nxt = S_PREFIX_OPC;
      default: begin
        if (!prefetchEmpty) begin
          take       = 1'b1;
          advanceTop = 1'b1;
          state_nxt  = S_GAP;
          case (state)
            S_PREFIX_OPC: begin
              if (is_prefix(prefetchTop))      ret_nxt = S_PREFIX_OPC;
              else if (has_modrm(prefetchTop)) ret_nxt = S_MODRM;
              else ret_nxt = imm_or_done(imm_len(prefetchTop, 3'b000));
            end
            S_MODRM: begin
              if (disp_len(prefetchTop) != 2'd0) ret_nxt = S_DISP0;
              else ret_nxt = imm_or_done(imm_len(instOpcode, prefetchTop[5:3]));
            end
            S_DISP0: ret_nxt = (dl_cur == 2'd2) ? S_DISP1 : imm_or_done(il_cur);
            S_DISP1: ret_nxt = imm_or_done(il_cur);
            S_IMM0:  ret_nxt = (il_cur >= 3'd2) ? S_IMM1 : S_DONE;
            S_IMM1:  ret_nxt = (il_cur == 3'd4) ? S_IMM2 : S_DONE;
            S_IMM2:  ret_nxt = S_IMM3;
            default: ret_nxt = S_DONE;
          endcase
        end
      end
    endcase
    // abort wins over everything, including a pop that would otherwise happen now
    if (RESET || flush) begin
      state_nxt  = S_PREFIX_OPC;
      ret_nxt    = S_PREFIX_OPC;
      advanceTop = 1'b0;
      take       = 1'b0;
    end
  end

  // record fields, length counter and gap timer
  always_ff @(posedge CLKx4) begin
    if (RESET || flush || (state == S_DONE && instReady)) begin
      instOpcode   <= 8'h00;
      instHasModrm <= 1'b0;
      instModrm    <= 8'h00;
      instDisp     <= 16'h0000;
      instImm      <= 32'h0000_0000;
      instSeg      <= 3'b100;
      instRep      <= 2'b00;
      instLock     <= 1'b0;
      instLength   <= 4'd0;
      gap_cnt      <= '0;
    end else if (take) begin
      gap_cnt <= '0;
      if (instLength != 4'(MAX_LEN)) instLength <= instLength + 4'd1;
      case (state)
        S_PREFIX_OPC: begin
          case (prefetchTop)
            8'h26: instSeg  <= 3'd0;
            8'h2E: instSeg  <= 3'd1;
            8'h36: instSeg  <= 3'd2;
            8'h3E: instSeg  <= 3'd3;
            8'hF2: instRep  <= 2'b10;
            8'hF3: instRep  <= 2'b11;
            8'hF0: instLock <= 1'b1;
            default: begin
              instOpcode   <= prefetchTop;
              instHasModrm <= has_modrm(prefetchTop);
            end
          endcase
        end
        S_MODRM: instModrm <= prefetchTop;
        S_DISP0: instDisp  <= (dl_cur == 2'd1) ? {{8{prefetchTop[7]}}, prefetchTop}
                                               : {8'h00, prefetchTop};
        S_DISP1: instDisp[15:8]  <= prefetchTop;
        S_IMM0:  instImm[7:0]    <= prefetchTop;
        S_IMM1:  instImm[15:8]   <= prefetchTop;
        S_IMM2:  instImm[23:16]  <= prefetchTop;
        S_IMM3:  instImm[31:24]  <= prefetchTop;
        default: ;
      endcase
    end else if (state == S_GAP) begin
      gap_cnt <= gap_cnt + GW'(1);
    end
  end

endmodule

// File: doc/queue_instruction_decoder.md
Name: queue_instruction_decoder

Overview:
- Sits directly downstream of the bus interface prefetch queue; consumes one byte at a time from prefetchTop.
- Issues the one-cycle advanceTop strobe to pop each byte.
- Assembles prefixes, opcode, ModRM, displacement and immediate into one instruction record.
- Presents the record to the execution unit with a valid/ready handshake.

Parameters:
- GAP_CYCLES, 1: low CLKx4 cycles after each advanceTop pulse before the next byte is sampled (min 1).
- MAX_LEN, 15: saturation value of instLength.

Ports:
- CLKx4  input  1  clock; all logic on posedge.
- RESET  input  1  reset; synchronous, active-high.
- prefetchTop  input  8  current queue head byte.
- prefetchEmpty  input  1  queue empty; byte invalid when 1.
- flush  input  1  level; abort current decode.
- advanceTop  output  1  pop strobe, exactly one CLKx4 cycle high per consumed byte.
- instValid  output  1  record valid.
- instReady  input  1  execution unit accepts record.
- instOpcode  output  8  opcode byte.
- instHasModrm  output  1  ModRM present.
- instModrm  output  8  ModRM byte (0 if absent).
- instDisp  output  16  displacement; disp8 sign-extended.
- instImm  output  32  immediate; little-endian packed; 4 bytes for far ptr (offset low, segment high).
- instSeg  output  3  override: 0 ES, 1 CS, 2 SS, 3 DS, 3'b100 none.
- instRep  output  2  00 none, 10 REPNE(F2), 11 REP(F3).
- instLock  output  1  F0 seen.
- instLength  output  4  bytes consumed including prefixes; saturates at MAX_LEN.

Behaviour:
- Reset:
  - advanceTop=0, instValid=0.
  - All fields 0 except instSeg=3'b100.
  - State IDLE.
- States: IDLE/PREFIX_OPC, MODRM, DISP0, DISP1, IMM0..IMM3, GAP, DONE.
- Byte consume:
  - In any fetch state with prefetchEmpty=0 at a posedge, capture prefetchTop and drive advanceTop=1 for that single cycle.
  - Then spend GAP_CYCLES in GAP with advanceTop=0.
  - Sample again only after GAP. Default cadence: 2 cycles per byte.
- prefetchEmpty=1 in a fetch state: stall, advanceTop=0, no field change.
- Prefixes:
  - 26/2E/36/3E set instSeg=0/1/2/3; last one wins.
  - F2/F3 set instRep; F0 sets instLock.
  - Stay in PREFIX_OPC.
  - Any other byte is the opcode.
- ModRM present:
  - opcode[7:6]=00 with opcode[2]=0.
  - 80-8F, C4-C7, D0-D3, D8-DF, F6, F7, FE, FF.
- Displacement length from ModRM:
  - mod=01: 1.
  - mod=10: 2.
  - mod=00 with rm=110: 2.
  - otherwise: 0.
- Immediate length:
  - 1 byte: opcode[7:6]=00 and [2:0]=100; 6A-7F are not 8088 except 70-7F; 70-7F; 80, 82, 83; A8; B0-B7; C6; CD; D4; D5; E0-E7; EB; F6 with reg=000.
  - 2 bytes: opcode[7:6]=00 and [2:0]=101; 81; A0-A3; A9; B8-BF; C2; CA; C7; E8; E9; F7 with reg=000.
  - 4 bytes: 9A, EA.
  - Otherwise 0.
- Fetch order: prefixes, opcode, ModRM, disp, imm.
- DONE:
  - instValid=1 registered the cycle after the final byte's GAP completes.
  - Zero-length-tail opcodes enter DONE after the opcode's GAP.
  - Fields are stable while instValid=1; no bytes are fetched.
  - instValid&instReady at a posedge: instValid=0, fields cleared, next cycle resume PREFIX_OPC.
- flush=1 at any posedge:
  - Overrides everything; advanceTop=0, instValid=0, fields cleared, state IDLE.
  - A pulse already driven this cycle is not repeated.
- Simultaneous flush and instReady: flush wins (record dropped).
- RESET mid-instruction: same as flush plus reset values; no partial record ever emitted.
- instLength: increments per consumed byte and saturates at MAX_LEN. Prefix floods continue consuming without wrap.
- advanceTop is never high in two consecutive cycles, and never high while prefetchEmpty=1 was sampled.

Test Plan:
- Queue 90 -> one 1-cycle advanceTop pulse; instValid with instOpcode=90, instHasModrm=0, instLength=1, instSeg=3'b100, within 3 cycles of byte available.
- Queue 2E 8B 46 FE -> 4 pulses spaced 2 cycles apart; instSeg=1, instModrm=46, instDisp=FFFE, instLength=4.
- Queue 81 06 34 12 78 56 -> instDisp=1234, instImm=00005678, instLength=6; EA 00 01 00 F0 -> instImm=F0000100, instLength=5.
- Queue B8, then prefetchEmpty=1 for 10 cycles, then 34 12 -> advanceTop low throughout stall; final instImm=00001234, instLength=3.
- Two records (F3 A4, then 40) with instReady low 5 cycles -> first record held stable, no pulses until accept; then second decoded with instRep=00.
- flush asserted after C7 06 consumed; RESET asserted mid B8 -> no instValid, advanceTop=0 next cycle, fields at reset values, next byte treated as new opcode.
